instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits[1:0] must be 0.
REQ-002 SHALL have ports clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have ports rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports imem_req, output, 1, instruction-memory read request.
REQ-005 SHALL have ports imem_addr, output, 32, byte address of the word requested.
REQ-006 SHALL have ports imem_ack, input, 1, read-complete strobe; imem_rdata valid in the same cycle.
REQ-007 SHALL have ports imem_rdata, input, 32, instruction word returned.
REQ-008 SHALL have ports redirect_valid, input, 1, and redirect_pc, input, 32: branch/jump target strobe and target.
REQ-009 SHALL have ports instr, output, 32, instruction word presented to the decode stage.
REQ-010 SHALL have ports instr_valid, output, 1, and instr_ready, input, 1: decode-side valid/ready handshake.
REQ-011 SHALL have ports instr_pc, output, 32, PC of the word on instr.

Function
REQ-012 SHALL hold a 32-bit PC; each accepted fetch advances it by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-013 SHALL implement FSM IDLE/REQ/DROP: IDLE -> REQ when occupancy < 2; REQ -> IDLE on imem_ack; REQ -> DROP on redirect_valid without imem_ack; DROP -> IDLE on imem_ack.
REQ-014 SHALL drive imem_req=1 in REQ and DROP only, and hold imem_addr stable from request start until imem_ack.
REQ-015 SHALL keep at most one memory request outstanding; imem_req is low for at least one cycle after each imem_ack (peak throughput one word per 2 cycles).
REQ-016 SHALL buffer returned words, with their PC, in a 2-entry FIFO; a new request starts only if occupancy is at most 1.
REQ-017 SHALL present the FIFO head on instr/instr_pc with instr_valid = (occupancy != 0); an entry pops on an edge with instr_valid and instr_ready both high.
REQ-018 SHALL push imem_rdata on imem_ack in REQ, and SHALL discard it in DROP.
REQ-019 SHALL, on redirect_valid: flush the FIFO, load PC = {redirect_pc[31:2],2'b00}, and discard any same-cycle imem_ack data. Redirect has priority over ack and pop.
REQ-020 SHALL, on redirect_valid in DROP, update PC and remain in DROP until imem_ack.
REQ-021 SHALL keep instr and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-022 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, PC=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
REQ-024 SHALL raise the first imem_req on the first rising edge after rst_n deasserts; a reset mid-request abandons it and drops any later ack until a new request starts.

Configuration
REQ-025 SHALL, with macro INSTR_FETCH_PREDECODE_EN defined, add outputs pd_opcode[5:0]=instr[31:26], pd_rs[3:0]=instr[25:22], pd_rt[3:0]=instr[21:18], pd_rd[3:0]=instr[17:14], all registered alongside each FIFO entry and 0 when empty.
REQ-026 SHALL, without INSTR_FETCH_PREDECODE_EN, omit those ports and registers entirely; all other behaviour is identical.

Verification
REQ-027 SHALL cover this scenario: reset release, ack 1 cycle after each req, instr_ready=1. Expected: imem_addr 0,4,8,...; instr_pc matches; one word every 2 cycles.
REQ-028 SHALL cover this scenario: instr_ready=0, continuous acks. Expected: exactly 2 words buffered, imem_req stays low, and instr holds the word from addr 0 stable.
REQ-029 SHALL cover this scenario: redirect_pc=32'h0000_0103 while a request is outstanding at addr 8, then an ack with 32'hDEAD_BEEF. Expected: the word is discarded, the next imem_addr is 32'h0000_0100, and the FIFO is empty.
REQ-030 SHALL cover this scenario: redirect and ack in the same cycle. Expected: the ack data is dropped, and the next request is to the redirect target.
REQ-031 SHALL cover this scenario: RESET_PC=32'hFFFF_FFF8, two fetches. Expected: addresses FFFF_FFF8, FFFF_FFFC, then 0000_0000.
REQ-032 SHALL cover this scenario: macro defined, rdata=32'hFC5A_4000. Expected: pd_opcode=6'h3F, pd_rs=4'h1, pd_rt=4'h6, pd_rd=4'h9.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: PC generator, single-outstanding instruction-memory requester and
// 2-entry instruction buffer feeding decode through a valid/ready handshake.
// Optional feature: define INSTR_FETCH_PREDECODE_EN to add registered predecode
// outputs (pd_opcode, pd_rs, pd_rt, pd_rd) carried with each buffered word.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc
`ifdef INSTR_FETCH_PREDECODE_EN
  ,
  output logic [5:0]  pd_opcode,
  output logic [3:0]  pd_rs,
  output logic [3:0]  pd_rt,
  output logic [3:0]  pd_rd
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  WORD_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // One buffered instruction: the word, its PC and (optionally) predecoded fields.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
`ifdef INSTR_FETCH_PREDECODE_EN
    logic [5:0]      opcode;
    logic [3:0]      rs;
    logic [3:0]      rt;
    logic [3:0]      rd;
`endif
  } entry_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   w_addr_nxt;
  logic              r_req;
  logic              w_req_nxt;
  logic              w_push;
  logic              w_pop;
  logic [XLEN-1:0]   w_redir_pc;

  entry_t            r_head;
  entry_t            r_tail;
  entry_t            w_head_nxt;
  entry_t            w_tail_nxt;
  entry_t            w_new;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_valid;
  logic              w_valid_nxt;

  // Build a buffer entry from a returned word and the address it was fetched from.
  function automatic entry_t mk_entry(input logic [XLEN-1:0] data,
                                      input logic [XLEN-1:0] pc);
    entry_t e;
    e      = '0;
    e.data = data;
    e.pc   = pc;
`ifdef INSTR_FETCH_PREDECODE_EN
    e.opcode = data[31:26];
    e.rs     = data[25:22];
    e.rt     = data[21:18];
    e.rd     = data[17:14];
`endif
    return e;
  endfunction

  // Redirect targets are forced to word alignment.
  assign w_redir_pc = redirect_pc & ALIGN_MASK;
  assign w_pop      = r_valid & instr_ready;
  assign w_new      = mk_entry(imem_rdata, r_addr);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next PC/request address, and the push decision for returned data.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end
        // Start a request only while there is room for its word in the buffer.
        if (r_count != CNT_FULL) begin
          w_state_nxt = S_REQ;
          w_addr_nxt  = redirect_valid ? w_redir_pc : r_pc;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          // The in-flight word belongs to the old path; drop it when it returns.
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          w_push      = 1'b1;
          w_pc_nxt    = r_addr + WORD_BYTES;
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end
        if (imem_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_req_nxt = (w_state_nxt != S_IDLE);

  // Buffer update: redirect flushes; otherwise push/pop on a 2-deep shift queue.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (redirect_valid) begin
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == '0) begin
            w_head_nxt = w_new;
          end else begin
            w_tail_nxt = w_new;
          end
          w_count_nxt = r_count + CNT_W'(1);
        end
        2'b01: begin
          w_head_nxt  = r_tail;
          w_tail_nxt  = '0;
          w_count_nxt = r_count - CNT_W'(1);
        end
        2'b11: begin
          if (r_count == CNT_W'(1)) begin
            w_head_nxt = w_new;
          end else begin
            w_head_nxt = r_tail;
            w_tail_nxt = w_new;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_valid_nxt = (w_count_nxt != '0);

  // Datapath registers: PC, request outputs and instruction buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= w_req_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_head.data;
  assign instr_pc    = r_head.pc;
  assign instr_valid = r_valid;

`ifdef INSTR_FETCH_PREDECODE_EN
  assign pd_opcode = r_head.opcode;
  assign pd_rs     = r_head.rs;
  assign pd_rt     = r_head.rt;
  assign pd_rd     = r_head.rd;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized traffic checked
// against a transaction-level model (expected request, buffered word queue).
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_pc;

  // Wrap-around DUT (RESET_PC near the top of the address space)
  logic        b_rst_n;
  logic        b_req;
  logic [31:0] b_addr;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        b_redir;
  logic [31:0] b_redir_pc;
  logic [31:0] b_instr;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_pc;

`ifdef INSTR_FETCH_PREDECODE_EN
  logic [5:0] pd_opcode, b_pd_opcode;
  logic [3:0] pd_rs, pd_rt, pd_rd, b_pd_rs, b_pd_rt, b_pd_rd;
`endif

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_pc(instr_pc)
`ifdef INSTR_FETCH_PREDECODE_EN
    , .pd_opcode(pd_opcode), .pd_rs(pd_rs), .pd_rt(pd_rt), .pd_rd(pd_rd)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst_n(b_rst_n),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(b_rdata),
    .redirect_valid(b_redir), .redirect_pc(b_redir_pc),
    .instr(b_instr), .instr_valid(b_valid), .instr_ready(b_ready),
    .instr_pc(b_pc)
`ifdef INSTR_FETCH_PREDECODE_EN
    , .pd_opcode(b_pd_opcode), .pd_rs(b_pd_rs), .pd_rt(b_pd_rt), .pd_rd(b_pd_rd)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending request (address, whether it was cancelled) and
  // a queue of delivered-but-unconsumed words.
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_drop;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc   = 32'h0;
    m_addr = 32'h0;
    m_busy = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, settle.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit ack,
                      input logic [31:0] rd, input bit rdy);
    bit   was_busy, start, pop;
    ent_t e;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = ack;
    imem_rdata     = rd;
    instr_ready    = rdy;
    @(posedge clk);
    was_busy = m_busy;
    start    = !m_busy && (m_q.size() < 2);
    pop      = (m_q.size() != 0) && rdy;
    if (rv) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (was_busy) begin
        if (ack) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (was_busy && ack) begin
        if (!m_drop) begin
          e.data = rd;
          e.pc   = m_addr;
          m_q.push_back(e);
          m_pc = m_addr + 32'd4;
        end
        m_busy = 1'b0;
        m_drop = 1'b0;
      end
    end
    if (start) begin
      m_busy = 1'b1;
      m_drop = 1'b0;
      m_addr = m_pc;
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hCAFE_0001, 0);
    step(0, 0, 0, 0, 0);
    // Now a request to 4 is outstanding with one word buffered; reset asynchronously.
    #2 rst_n = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // Stray ack from the abandoned request lands at the first edge and must be ignored.
    step(0, 0, 1, 32'hBAD0_BAD0, 0);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stray_ack: got valid=%b want 0", instr_valid); end
  endtask

  task automatic test_stream();
    int nreq = 0, nword = 0;
    bit prev_req = 1'b0;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      step(0, 0, m_busy, pattern(m_addr), 1);
      if (imem_req && !prev_req) begin
        tests++; if (imem_addr !== 32'(4 * nreq)) begin
          fails++; $display("FAIL stream_addr: got %h want %h", imem_addr, 32'(4 * nreq)); end
        nreq++;
      end
      prev_req = imem_req;
      if (instr_valid) begin
        tests++; if (instr_pc !== 32'(4 * nword) || instr !== pattern(32'(4 * nword))) begin
          fails++; $display("FAIL stream_word: got pc=%h instr=%h want pc=%h", instr_pc, instr, 32'(4 * nword)); end
        nword++;
      end
    end
    tests++; if (nword != 12 || nreq != 12) begin
      fails++; $display("FAIL stream_rate: got words=%0d reqs=%0d want 12/12", nword, nreq); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(0, 0, 1, pattern(m_addr), 0);
      if (c >= 4) begin
        tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== pattern(32'h0) || instr_pc !== 32'h0) begin
          fails++; $display("FAIL bp_hold: got req=%b valid=%b instr=%h pc=%h", imem_req, instr_valid, instr, instr_pc); end
      end
    end
    step(0, 0, 0, 0, 1);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== pattern(32'h4) || imem_req !== 1'b0) begin
      fails++; $display("FAIL bp_second: got valid=%b pc=%h instr=%h req=%b", instr_valid, instr_pc, instr, imem_req); end
    step(0, 0, 0, 0, 1);
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      fails++; $display("FAIL bp_drain: got valid=%b req=%b addr=%h want 0/1/8", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    int guard = 0;
    do_reset();
    while (!(imem_req && imem_addr == 32'h8) && guard < 20) begin
      step(0, 0, m_busy, pattern(m_addr), instr_valid && instr_pc == 32'h0);
      guard++;
    end
    tests++; if (guard >= 20) begin fails++; $display("FAIL redir_setup: timeout waiting for addr 8"); end
    step(1, 32'h0000_0103, 0, 0, 0);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL redir_flush: got req=%b addr=%h valid=%b want 1/8/0", imem_req, imem_addr, instr_valid); end
    step(0, 0, 1, 32'hDEAD_BEEF, 1);
    tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL redir_drop: got req=%b valid=%b want 0/0", imem_req, instr_valid); end
    step(0, 0, 0, 0, 0);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      fails++; $display("FAIL redir_target: got req=%b addr=%h want 1/00000100", imem_req, imem_addr); end
    step(0, 0, 1, 32'h1111_2222, 0);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h1111_2222) begin
      fails++; $display("FAIL redir_word: got valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    step(0, 0, 0, 0, 1);
    step(1, 32'h0000_2002, 1, 32'hBAD_C0DE, 1);
    tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL rack_drop: got req=%b valid=%b want 0/0", imem_req, instr_valid); end
    step(0, 0, 0, 0, 0);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin
      fails++; $display("FAIL rack_target: got req=%b addr=%h want 1/00002000", imem_req, imem_addr); end
    step(0, 0, 1, 32'h600D_600D, 0);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2000 || instr !== 32'h600D_600D) begin
      fails++; $display("FAIL rack_word: got valid=%b pc=%h instr=%h", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    int nreq = 0;
    bit prev = 1'b0;
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    b_rst_n = 1'b0; b_ack = 1'b0; b_rdata = 32'h0; b_redir = 1'b0; b_redir_pc = 32'h0; b_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (b_req && !prev) begin
        if (nreq < 3) begin
          tests++; if (b_addr !== exp_addr[nreq]) begin
            fails++; $display("FAIL wrap_addr: got %h want %h", b_addr, exp_addr[nreq]); end
        end
        nreq++;
      end
      prev    = b_req;
      b_ack   = b_req;
      b_rdata = pattern(b_addr);
    end
    tests++; if (nreq != 3) begin fails++; $display("FAIL wrap_count: got %0d requests want 3", nreq); end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 16) == 0, $urandom, m_busy && (($urandom % 3) != 0), $urandom, ($urandom % 4) != 0);
      tests++;
      if (imem_req !== m_busy || imem_addr !== m_addr || instr_valid !== (m_q.size() != 0) ||
          (m_q.size() != 0 && (instr !== m_q[0].data || instr_pc !== m_q[0].pc))) begin
        fails++;
        if (bad < 10) $display("FAIL random_cycle %0d: got req=%b addr=%h valid=%b instr=%h pc=%h want req=%b addr=%h valid=%b",
                               c, imem_req, imem_addr, instr_valid, instr, instr_pc, m_busy, m_addr, m_q.size() != 0);
        bad++;
      end
    end
  endtask

`ifdef INSTR_FETCH_PREDECODE_EN
  task automatic test_predecode();
    do_reset();
    step(0, 0, 0, 0, 0);
    tests++; if (pd_opcode !== 6'h0 || pd_rs !== 4'h0 || pd_rt !== 4'h0 || pd_rd !== 4'h0) begin
      fails++; $display("FAIL pd_empty: got %h %h %h %h want zeros", pd_opcode, pd_rs, pd_rt, pd_rd); end
    step(0, 0, 1, 32'hFC5A_4000, 0);
    tests++; if (pd_opcode !== 6'h3F || pd_rs !== 4'h1 || pd_rt !== 4'h6 || pd_rd !== 4'h9) begin
      fails++; $display("FAIL pd_fields: got %h %h %h %h want 3f 1 6 9", pd_opcode, pd_rs, pd_rt, pd_rd); end
  endtask
`endif

  initial begin
    b_rst_n = 1'b0; b_ack = 1'b0; b_rdata = 32'h0; b_redir = 1'b0; b_redir_pc = 32'h0; b_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_ack();
    test_wrap();
    test_random();
`ifdef INSTR_FETCH_PREDECODE_EN
    test_predecode();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
